pipelined_carry_adder: RTL and testbench
========================================

Name: pipelined_carry_adder

Overview:
Parametrised pipelined ripple-carry adder/subtractor. It splits a WIDTH-bit add into STAGES equal segments and registers the inter-segment carry, so each cycle ripples only WIDTH/STAGES bits. It adds a valid/ready handshake with full backpressure, a subtract mode and a signed-overflow flag. It serves as the ALU/AGU adder wherever a single-cycle 64-bit ripple path misses timing.

Parameters:
WIDTH, 64, operand/result width in bits; must be a multiple of STAGES.
STAGES, 4, pipeline segments, 1..WIDTH; segment width SEG = WIDTH/STAGES.
USE_AOI, 0, nonzero selects the AOI full-adder cell inside segments; otherwise the standard full-adder cell.

Ports:
clk  input  1  clock; all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand beat offered.
in_ready  output  1  block accepts beat this cycle.
in1  input  WIDTH  operand A.
in2  input  WIDTH  operand B.
ci  input  1  carry-in; ignored when sub=1.
sub  input  1  1 = A - B computed as A + ~B + 1.
out_valid  output  1  result beat present.
out_ready  input  1  consumer accepts result.
sum  output  WIDTH  result.
co  output  1  carry-out; when sub=1 this is NOT-borrow (1 = no borrow).
ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async assert, sync release via clk): every stage valid bit = 0, out_valid=0, sum=0, co=0, ovf=0. In-flight beats are discarded; nothing stale emerges after release.
- Accept: a beat transfers when in_valid && in_ready. The effective B is in2^{WIDTH{sub}}; the effective carry-in is sub ? 1 : ci.
- Stage k (0..STAGES-1) combinationally adds bits [k*SEG +: SEG] using the registered carry from stage k-1 (stage 0 uses the effective carry-in), then registers:
  - its sum slice;
  - all lower sum slices already computed;
  - the unconsumed upper operand bits;
  - the carry out;
  - for the final stage only, the MSB carry-in for ovf.
- Outputs are driven directly from the last stage register; there is no combinational path from inputs to outputs.
- Latency: exactly STAGES cycles from accept to out_valid with no stall. Throughput: 1 beat/cycle.
- Stall rule: stage k loads when it is empty or stage k+1 (or the consumer, for the last stage) moves this cycle. in_ready = stage-0 load condition. A combinational out_ready -> in_ready path is intended.
- A stage that holds but does not move keeps its contents bit-stable; out data must not change while out_valid && !out_ready.
- Capacity: STAGES beats. When full with out_ready=0, in_ready=0.
- Simultaneous pop and push on a full pipe: both occur; occupancy is unchanged.
- Order is strictly FIFO; no beat is dropped or duplicated.
- STAGES=1: a single register stage, latency 1, in_ready = !out_valid || out_ready.
- STAGES=WIDTH: one bit per stage; must be legal.
- Elaboration error if WIDTH % STAGES != 0 or STAGES < 1.

Decomposition:
- Package pipelined_carry_adder_pkg holds:
  - function seg_width(WIDTH, STAGES);
  - localparam checks;
  - the stage payload struct typedef (sum_lo, op_a_hi, op_b_hi, carry, msb_ci).
- One natural sub-module, adder_segment: a combinational SEG-bit ripple chain of full-adder cells (AOI or standard per USE_AOI) exposing the carry into its MSB. The top instantiates STAGES segments plus the stage registers and handshake.

Test Plan:
1. WIDTH=8, STAGES=4, out_ready=1: A=0xFF, B=0x01, ci=0, sub=0 -> sum=0x00, co=1, ovf=0; out_valid exactly 4 cycles after accept.
2. Same configuration, subtract:
   - sub=1, A=0x05, B=0x07 -> sum=0xFE, co=0, ovf=0.
   - A=0x80, B=0x01 -> sum=0x7F, co=1, ovf=1.
   - ci toggled during subtract has no effect.
3. Streaming: 16 back-to-back random beats, out_ready=1 -> 16 results on consecutive cycles, in order, each matching the A±B model including co/ovf.
4. Backpressure: out_ready=0 for 8 cycles while in_valid=1 -> exactly 4 beats accepted and in_ready=0 afterwards, sum held stable. Then release with randomised out_ready toggling -> all beats delivered once, in order.
5. Reset mid-flight: assert rst_n=0 asynchronously with 3 beats in flight -> out_valid=0 and sum=0 immediately; after release with in_valid=0, no output for 10 cycles.
6. WIDTH=64, STAGES=1: A=0x7FFF_FFFF_FFFF_FFFF, B=1, ci=0 -> sum=0x8000_0000_0000_0000, co=0, ovf=1, latency 1. Repeat with STAGES=64 -> same result, latency 64.

Source files
------------

// File: rtl/pipelined_carry_adder_pkg.sv
// Shared sizing helpers, configuration checks and stage flag typedef for the pipelined
// carry adder.
package pipelined_carry_adder_pkg;

    localparam int unsigned MinStages = 1;

    // Carry and MSB carry-in travel together through every stage register.
    typedef struct packed {
        logic carry;
        logic msb_ci;
    } stage_flags_t;

    function automatic int unsigned seg_width(input int unsigned width, input int unsigned stages);
        return (stages == 0) ? width : width / stages;
    endfunction

    function automatic bit cfg_valid(input int unsigned width, input int unsigned stages);
        return (stages >= MinStages) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_segment.sv
// Combinational SEG-bit ripple-carry segment built from standard or AOI full-adder cells.
module adder_segment
    import pipelined_carry_adder_pkg::*;
#(
    parameter int unsigned SEG     = 16,
    parameter int unsigned USE_AOI = 0
) (
    input  logic [SEG-1:0] i_a,
    input  logic [SEG-1:0] i_b,
    input  logic           i_ci,
    output logic [SEG-1:0] o_sum,
    output logic           o_co,
    output logic           o_msb_ci
);

    logic [SEG:0]   w_carry;
    logic [SEG-1:0] w_sum;
    logic           w_co_n;

    always_comb begin
        w_carry    = '0;
        w_sum      = '0;
        w_co_n     = 1'b0;
        w_carry[0] = i_ci;
        for (int unsigned i = 0; i < SEG; i++) begin
            if (USE_AOI != 0) begin
                // Mirror-adder form: inverted carry is reused to build the sum.
                w_co_n       = ~((i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] | i_b[i])));
                w_sum[i]     = ((i_a[i] | i_b[i] | w_carry[i]) & w_co_n)
                               | (i_a[i] & i_b[i] & w_carry[i]);
                w_carry[i+1] = ~w_co_n;
            end else begin
                w_sum[i]     = i_a[i] ^ i_b[i] ^ w_carry[i];
                w_carry[i+1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
            end
        end
    end

    assign o_sum    = w_sum;
    assign o_co     = w_carry[SEG];
    assign o_msb_ci = w_carry[SEG-1];

endmodule

// File: rtl/pipelined_carry_adder.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES registered segments
// with a valid/ready handshake and full backpressure.
module pipelined_carry_adder #(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned STAGES  = 4,
    parameter int unsigned USE_AOI = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);
    import pipelined_carry_adder_pkg::*;

    localparam int unsigned SEG  = seg_width(WIDTH, STAGES);
    localparam int unsigned LAST = STAGES - 1;

    if (!cfg_valid(WIDTH, STAGES)) begin : g_cfg_check
        $error("pipelined_carry_adder: STAGES must be >= 1 and divide WIDTH");
    end

    // sum_lo: finished low slices; op_*_hi: operand bits not yet consumed.
    typedef struct packed {
        logic [WIDTH-1:0] sum_lo;
        logic [WIDTH-1:0] op_a_hi;
        logic [WIDTH-1:0] op_b_hi;
        stage_flags_t     flags;
    } stage_t;

    stage_t            w_in;
    stage_t            r_stage [STAGES];
    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] w_load;

    always_comb begin
        w_in             = '0;
        w_in.op_a_hi     = in1;
        w_in.op_b_hi     = in2 ^ {WIDTH{sub}};
        w_in.flags.carry = sub | ci;
    end

    // A stage loads when empty or when its successor (or the consumer) takes its beat.
    always_comb begin
        w_load       = '0;
        w_load[LAST] = !r_valid[LAST] || out_ready;
        for (int k = int'(STAGES) - 2; k >= 0; k--) begin
            w_load[k] = !r_valid[k] || w_load[k+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t         w_src;
        stage_t         w_nxt;
        logic           w_src_valid;
        logic [SEG-1:0] w_seg_sum;
        logic           w_seg_co;
        logic           w_seg_msb_ci;

        if (k == 0) begin : g_head
            assign w_src       = w_in;
            assign w_src_valid = in_valid;
        end else begin : g_chain
            assign w_src       = r_stage[k-1];
            assign w_src_valid = r_valid[k-1];
        end

        adder_segment #(
            .SEG     (SEG),
            .USE_AOI (USE_AOI)
        ) u_seg (
            .i_a      (w_src.op_a_hi[k*SEG +: SEG]),
            .i_b      (w_src.op_b_hi[k*SEG +: SEG]),
            .i_ci     (w_src.flags.carry),
            .o_sum    (w_seg_sum),
            .o_co     (w_seg_co),
            .o_msb_ci (w_seg_msb_ci)
        );

        // Only the last stage's msb_ci survives to the output; earlier copies are overwritten.
        always_comb begin
            w_nxt                       = w_src;
            w_nxt.sum_lo[k*SEG +: SEG]  = w_seg_sum;
            w_nxt.flags.carry           = w_seg_co;
            w_nxt.flags.msb_ci          = w_seg_msb_ci;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid[k] <= 1'b0;
                r_stage[k] <= '0;
            end else if (w_load[k]) begin
                r_valid[k] <= w_src_valid;
                if (w_src_valid) begin
                    r_stage[k] <= w_nxt;
                end
            end
        end
    end

    assign in_ready  = w_load[0];
    assign out_valid = r_valid[LAST];
    assign sum       = r_stage[LAST].sum_lo;
    assign co        = r_stage[LAST].flags.carry;
    assign ovf       = r_stage[LAST].flags.carry ^ r_stage[LAST].flags.msb_ci;

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Self-checking bench: three adder configurations driven with directed and random beats,
// checked against an arithmetic reference model.
module tb_pipelined_carry_adder;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // Index 0: WIDTH=8/STAGES=4, 1: WIDTH=64/STAGES=1, 2: WIDTH=64/STAGES=64 (AOI cells).
    logic        vld  [3];
    logic        rdy  [3];
    logic        ordy [3];
    logic        ovld [3];
    logic        cin  [3];
    logic        sbt  [3];
    logic        cout [3];
    logic        ovfl [3];
    logic [63:0] opa  [3];
    logic [63:0] opb  [3];
    logic [7:0]  sum8;
    logic [63:0] sum_s1;
    logic [63:0] sum_s64;

    logic [65:0] exp_q [$];
    logic [65:0] obs_q [$];
    int          obs_cyc [$];
    int          acc_first;
    int          acc_last;
    int          checks = 0;
    int          passes = 0;

    pipelined_carry_adder #(.WIDTH(8), .STAGES(4), .USE_AOI(0)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(rdy[0]),
        .in1(opa[0][7:0]), .in2(opb[0][7:0]), .ci(cin[0]), .sub(sbt[0]),
        .out_valid(ovld[0]), .out_ready(ordy[0]), .sum(sum8), .co(cout[0]), .ovf(ovfl[0])
    );

    pipelined_carry_adder #(.WIDTH(64), .STAGES(1), .USE_AOI(0)) u_dut_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(rdy[1]),
        .in1(opa[1]), .in2(opb[1]), .ci(cin[1]), .sub(sbt[1]),
        .out_valid(ovld[1]), .out_ready(ordy[1]), .sum(sum_s1), .co(cout[1]), .ovf(ovfl[1])
    );

    pipelined_carry_adder #(.WIDTH(64), .STAGES(64), .USE_AOI(1)) u_dut_s64 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[2]), .in_ready(rdy[2]),
        .in1(opa[2]), .in2(opb[2]), .ci(cin[2]), .sub(sbt[2]),
        .out_valid(ovld[2]), .out_ready(ordy[2]), .sum(sum_s64), .co(cout[2]), .ovf(ovfl[2])
    );

    function automatic int wid(input int sel);
        return (sel == 0) ? 8 : 64;
    endfunction

    function automatic logic [63:0] mask_of(input int w);
        return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] res_of(input int sel);
        case (sel)
            0:       return {56'd0, sum8};
            1:       return sum_s1;
            default: return sum_s64;
        endcase
    endfunction

    function automatic logic [65:0] obs_of(input int sel);
        return {cout[sel], ovfl[sel], res_of(sel)};
    endfunction

    // Reference: two's-complement add with subtract as A + ~B + 1; overflow from operand signs.
    function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic c, input logic s, input int w);
        logic [63:0] m, am, be, r;
        logic [64:0] full;
        logic        c_out, v;
        m     = mask_of(w);
        am    = a & m;
        be    = (s ? ~b : b) & m;
        full  = {1'b0, am} + {1'b0, be} + {64'd0, (s ? 1'b1 : c)};
        r     = full[63:0] & m;
        c_out = full[w];
        v     = (am[w-1] == be[w-1]) && (r[w-1] != am[w-1]);
        return {c_out, v, r};
    endfunction

    task automatic new_beat(input int sel);
        opa[sel] = {$urandom(), $urandom()} & mask_of(wid(sel));
        opb[sel] = {$urandom(), $urandom()} & mask_of(wid(sel));
        cin[sel] = 1'($urandom());
        sbt[sel] = 1'($urandom());
    endtask

    task automatic run_single(input int sel, input logic [63:0] a, input logic [63:0] b,
                              input logic c, input logic s, output logic [65:0] r,
                              output int lat);
        int n;
        @(posedge clk); #1;
        opa[sel] = a; opb[sel] = b; cin[sel] = c; sbt[sel] = s;
        vld[sel] = 1'b1; ordy[sel] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rdy[sel] && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        vld[sel] = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!ovld[sel] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        r = obs_of(sel);
    endtask

    // Drives n random beats and collects every emitted result into obs_q.
    task automatic stream(input int sel, input int n, input bit rand_in, input bit rand_out);
        int sent, cyc, idle;
        bit acc;
        sent = 0; cyc = 0; idle = 0; acc_first = -1; acc_last = -1;
        @(posedge clk); #1;
        vld[sel] = 1'b0;
        if (n > 0 && (!rand_in || $urandom_range(0, 1) == 1)) begin
            new_beat(sel);
            vld[sel] = 1'b1;
        end
        ordy[sel] = rand_out ? 1'($urandom()) : 1'b1;
        while (idle < 10 && cyc < 3000) begin
            @(negedge clk);
            acc = vld[sel] && rdy[sel];
            if (acc) begin
                exp_q.push_back(model(opa[sel], opb[sel], cin[sel], sbt[sel], wid(sel)));
                sent++;
                if (acc_first < 0) acc_first = cyc;
                acc_last = cyc;
            end
            if (ovld[sel] && ordy[sel]) begin
                obs_q.push_back(obs_of(sel));
                obs_cyc.push_back(cyc);
            end
            if (sent >= n && obs_q.size() >= exp_q.size()) idle++;
            @(posedge clk); #1;
            if (acc) vld[sel] = 1'b0;
            if (!vld[sel] && sent < n && (!rand_in || $urandom_range(0, 1) == 1)) begin
                new_beat(sel);
                vld[sel] = 1'b1;
            end
            ordy[sel] = rand_out ? 1'($urandom()) : 1'b1;
            cyc++;
        end
        vld[sel]  = 1'b0;
        ordy[sel] = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (ovld[s] !== 1'b0) $display("FAIL reset_out_valid[%0d]: got %b want 0", s, ovld[s]);
            else passes++;
            checks++;
            if (obs_of(s) !== 66'd0) $display("FAIL reset_outputs[%0d]: got %h want 0", s, obs_of(s));
            else passes++;
        end
        checks++;
        if (rdy[0] !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", rdy[0]);
        else passes++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add_latency();
        logic [65:0] r;
        int lat;
        run_single(0, 64'hFF, 64'h01, 1'b0, 1'b0, r, lat);
        checks++;
        if (r !== {1'b1, 1'b0, 64'h00}) $display("FAIL add_ff_01: got %h want %h", r, {1'b1, 1'b0, 64'h00});
        else passes++;
        checks++;
        if (lat !== 4) $display("FAIL add_latency: got %0d want 4", lat);
        else passes++;
        run_single(0, 64'h3C, 64'h4D, 1'b1, 1'b0, r, lat);
        checks++;
        if (r !== {1'b0, 1'b1, 64'h8A}) $display("FAIL add_ci_ovf: got %h want %h", r, {1'b0, 1'b1, 64'h8A});
        else passes++;
    endtask

    task automatic test_subtract();
        logic [65:0] r;
        int lat;
        for (int c = 0; c < 2; c++) begin
            run_single(0, 64'h05, 64'h07, 1'(c), 1'b1, r, lat);
            checks++;
            if (r !== {1'b0, 1'b0, 64'hFE}) $display("FAIL sub_05_07 ci=%0d: got %h want %h", c, r, {1'b0, 1'b0, 64'hFE});
            else passes++;
            run_single(0, 64'h80, 64'h01, 1'(c), 1'b1, r, lat);
            checks++;
            if (r !== {1'b1, 1'b1, 64'h7F}) $display("FAIL sub_80_01 ci=%0d: got %h want %h", c, r, {1'b1, 1'b1, 64'h7F});
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
        stream(0, 16, 1'b0, 1'b0);
        checks++;
        if (obs_q.size() != 16) $display("FAIL b2b_count: got %0d want 16", obs_q.size());
        else passes++;
        for (int i = 0; i < 16 && i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL b2b_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            else passes++;
        end
        checks++;
        if (obs_cyc.size() != 16 || obs_cyc[15] - obs_cyc[0] != 15)
            $display("FAIL b2b_out_span: got %0d results, span %0d want 15",
                     obs_cyc.size(), (obs_cyc.size() > 0) ? obs_cyc[obs_cyc.size()-1] - obs_cyc[0] : -1);
        else passes++;
        checks++;
        if (acc_last - acc_first != 15) $display("FAIL b2b_accept_span: got %0d want 15", acc_last - acc_first);
        else passes++;
    endtask

    task automatic test_backpressure();
        int accepts;
        bit acc, held_set;
        logic [65:0] held;
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
        accepts = 0; held_set = 1'b0; held = '0;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        new_beat(0);
        vld[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            acc = vld[0] && rdy[0];
            if (acc) begin
                exp_q.push_back(model(opa[0], opb[0], cin[0], sbt[0], 8));
                accepts++;
            end
            if (ovld[0]) begin
                if (!held_set) begin
                    held = obs_of(0);
                    held_set = 1'b1;
                end else begin
                    checks++;
                    if (obs_of(0) !== held) $display("FAIL bp_hold_cycle%0d: got %h want %h", i, obs_of(0), held);
                    else passes++;
                end
            end
            @(posedge clk); #1;
            if (acc) new_beat(0);
        end
        checks++;
        if (accepts != 4) $display("FAIL bp_accepts: got %0d want 4", accepts);
        else passes++;
        checks++;
        if (rdy[0] !== 1'b0) $display("FAIL bp_in_ready_full: got %b want 0", rdy[0]);
        else passes++;
        checks++;
        if (ovld[0] !== 1'b1) $display("FAIL bp_out_valid_held: got %b want 1", ovld[0]);
        else passes++;
        vld[0] = 1'b0;
        stream(0, 0, 1'b0, 1'b1);
        checks++;
        if (obs_q.size() != 4) $display("FAIL bp_drain_count: got %0d want 4", obs_q.size());
        else passes++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL bp_drain_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            else passes++;
        end
    endtask

    task automatic test_reset_midflight();
        @(posedge clk); #1;
        ordy[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            opa[0] = 64'h11 + 64'(i); opb[0] = 64'h22; cin[0] = 1'b0; sbt[0] = 1'b0;
            vld[0] = 1'b1;
            @(posedge clk); #1;
        end
        vld[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs_of(0) !== {1'b0, 1'b0, 64'h33} || ovld[0] !== 1'b1)
            $display("FAIL midrst_pre: got valid=%b %h want valid=1 %h", ovld[0], obs_of(0), {1'b0, 1'b0, 64'h33});
        else passes++;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ovld[0] !== 1'b0) $display("FAIL midrst_out_valid: got %b want 0", ovld[0]);
        else passes++;
        checks++;
        if (obs_of(0) !== 66'd0) $display("FAIL midrst_outputs: got %h want 0", obs_of(0));
        else passes++;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (ovld[0] !== 1'b0) $display("FAIL midrst_stale_cycle%0d: got %b want 0", i, ovld[0]);
            else passes++;
        end
    endtask

    task automatic test_wide(input int sel, input int want_lat);
        logic [65:0] r, want;
        int lat;
        want = {1'b0, 1'b1, 64'h8000_0000_0000_0000};
        run_single(sel, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, r, lat);
        checks++;
        if (r !== want) $display("FAIL wide%0d_maxpos_plus1: got %h want %h", sel, r, want);
        else passes++;
        checks++;
        if (lat != want_lat) $display("FAIL wide%0d_latency: got %0d want %0d", sel, lat, want_lat);
        else passes++;
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
        stream(sel, 12, 1'b1, 1'b1);
        checks++;
        if (obs_q.size() != 12) $display("FAIL wide%0d_count: got %0d want 12", sel, obs_q.size());
        else passes++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL wide%0d_beat%0d: got %h want %h", sel, i, obs_q[i], exp_q[i]);
            else passes++;
        end
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            vld[s] = 1'b0; ordy[s] = 1'b1; cin[s] = 1'b0; sbt[s] = 1'b0;
            opa[s] = '0; opb[s] = '0;
        end
        test_reset();
        test_add_latency();
        test_subtract();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_wide(1, 1);
        test_wide(2, 64);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", passes, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
